// File: rtl/imem_loader_if.sv
// Stream-in and IMEM-write bus of the program loader.
// The slave side is the loader. The master side is whoever feeds bytes and owns the memory.
interface imem_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: MAGIC, 16-bit word count, payload, checksum.
// Keeps the core in reset until a frame with a good checksum has been written.
module imem_loader #(
  parameter int          ADDR_W  = 12,
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_loader_if.slave      bus,
  input  logic              restart,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [15:0] MAX_WORDS = 16'(2 ** (ADDR_W - 2));
  localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W-2:0] nwords_q, nwords_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-2:0] words_q, words_d;

  logic              in_ready;
  logic              accept;
  logic              active;
  logic              tmo_fire;
  logic [15:0]       frame_len;
  logic [ADDR_W-1:0] last_idx;

  assign in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept    = bus.in_valid && in_ready;
  assign active    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
  assign tmo_fire  = (TIMEOUT != 16'd0) && active && (tmo_q == TMO_LAST);
  assign frame_len = {len_hi_q, bus.in_data};
  // For the largest frame 4*N wraps to zero, so minus one still lands on the top address.
  assign last_idx  = {nwords_q[ADDR_W-3:0], 2'b00} - ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    nwords_d     = nwords_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    tmo_d        = '0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;
    words_d      = words_q;

    if (restart) begin
      state_d      = S_IDLE;
      core_rst_n_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      cnt_d        = '0;
      csum_d       = '0;
    end else if (tmo_fire) begin
      state_d = S_ERROR;
      error_d = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_data == MAGIC) state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if ((frame_len == 16'd0) || (frame_len > MAX_WORDS)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            nwords_d = frame_len[ADDR_W-2:0];
            cnt_d    = '0;
            csum_d   = '0;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = bus.in_data;
          csum_d      = csum_q + bus.in_data;
          cnt_d       = cnt_q + ADDR_W'(1);
          if (cnt_q == last_idx) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (bus.in_data == csum_q) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
            words_d      = nwords_q;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (active) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      nwords_q     <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      nwords_q     <= nwords_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst_n    = core_rst_n_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the instruction memory that the core fetches from.
- Accepts a framed byte stream over a valid/ready interface, checks it, and writes the payload byte-by-byte into the 4 KB byte-addressed IMEM starting at address 0.
- Bytes are stored in stream order, so the first stream byte of each word lands at the lowest address, which the core fetches as the most significant byte.
- Holds the core in reset (core_rst_n low) until a frame loads with a good checksum.

Parameters:
ADDR_W, 12, IMEM byte-address width (2^ADDR_W bytes).
MAGIC, 8'hA5, frame start byte.
TIMEOUT, 16'd50000, max cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  stream byte.
in_ready  output  1  loader can accept a byte.
restart  input  1  single-cycle pulse that aborts the current load and returns to IDLE.
mem_we  output  1  IMEM byte write enable.
mem_addr  output  ADDR_W  IMEM byte address.
mem_wdata  output  8  IMEM write data.
core_rst_n  output  1  core reset, active-low, registered.
done  output  1  load completed with good checksum.
error  output  1  load failed.
words_loaded  output  ADDR_W-1  word count of the last successful load.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs cleared.
  - state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rst_n=0, done=0, error=0, words_loaded=0.
  - Internal byte counter, checksum and timeout counter cleared.
- Byte acceptance: a byte is accepted on a clock edge where in_valid && in_ready. in_data is sampled only on that edge.
- in_ready:
  - 1 in IDLE, LEN_HI, LEN_LO, DATA and CHECK.
  - 0 in DONE and ERROR.
- Frame format: MAGIC, then word count N (16-bit, big-endian), then 4*N payload bytes, then 1 checksum byte. The checksum byte equals the sum of all payload bytes mod 256.
- State transitions (each taken on an accepted byte unless noted):
  - IDLE: accepted byte == MAGIC -> LEN_HI. Any other byte is accepted and discarded.
  - LEN_HI: store the high count byte -> LEN_LO.
  - LEN_LO: form N from the two count bytes.
    - N==0 or N>2^(ADDR_W-2) -> ERROR.
    - Otherwise clear the byte counter and checksum -> DATA.
  - DATA: on each accepted byte, register a write on the next cycle.
    - mem_we=1 for exactly one cycle, mem_addr=byte counter, mem_wdata=byte.
    - Checksum += byte (8-bit wrap); byte counter += 1.
    - After byte 4*N-1 -> CHECK.
  - CHECK: accepted byte == checksum -> DONE, with words_loaded=N and done=1. Mismatch -> ERROR with error=1.
  - DONE: core_rst_n=1 from the first cycle in DONE. Held until restart or rst_n.
  - ERROR: core_rst_n stays 0, error=1. Held until restart or rst_n.
- Write latency: the write appears 1 cycle after byte acceptance. Back-to-back accepted bytes give back-to-back writes.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- Timeout (TIMEOUT>0):
  - Counter runs in LEN_HI, LEN_LO, DATA and CHECK. It clears on every accepted byte and on state entry.
  - Reaching TIMEOUT -> ERROR.
  - IDLE has no timeout.
- restart pulse, in any state:
  - Next state is IDLE. core_rst_n=0, done=0 and error=0 on the next edge.
  - Counters clear. words_loaded is retained.
  - restart has priority over a byte accepted in the same cycle; that byte is dropped.
  - A write already registered from the previous cycle still completes.
- A byte accepted in the same cycle that the timeout fires is dropped; ERROR wins.
- Reloading overwrites only addresses 0..4N-1. Bytes beyond that are untouched.
- rst_n asserted mid-frame: immediate return to reset values. mem_we drops asynchronously.

Test Plan:
- Good load: stream A5 00 02 00 00 05 B3 00 10 01 13 DC, in_valid held high.
  - Writes to addr 0..7 in consecutive cycles with data 00,00,05,B3,00,10,01,13.
  - Then done=1, core_rst_n=1, words_loaded=2, in_ready=0.
- Bad checksum: same frame ending in DD instead of DC.
  - 8 writes occur, then error=1, core_rst_n=0, done=0.
- Garbage before the frame and a zero-length frame:
  - 00 FF 12 then a valid 1-word frame loads normally.
  - A5 00 00 -> ERROR with no writes.
- Oversize count: A5 04 01 (N=1025 with ADDR_W=12) -> ERROR with no writes.
- Stall and timeout: TIMEOUT=20; send A5 00 01 11 22, then idle 20 cycles.
  - Writes at addr 0,1, then error=1.
  - Random in_valid gaps shorter than 20 cycles must still load correctly.
- Restart:
  - In DONE, pulse restart -> core_rst_n=0 and in_ready=1 next cycle; a second frame then loads.
  - Restart mid-DATA -> IDLE; subsequent writes only from the new frame.
  - Assert rst_n mid-frame -> all outputs return to reset values immediately.
